// File: rtl/magnitude_arbiter_if.sv
// ============================================================================
//  Module      : magnitude_arbiter_if
//  Description : Handshake bundle between the requesters / result consumer
//                and the shared magnitude datapath (magnitude_arbiter).
//  Ports       : req       - per-requester request, held until ack
//                req_data  - NUM_REQ packed 17-bit samples, lane i at [17i+:17]
//                ack       - one-cycle grant pulse per requester
//                out_valid - result available
//                out_ready - consumer accepts result
//                out_mag   - 16-bit magnitude
//                out_id    - index of requester that produced out_mag
//                out_ovf   - sample was -65536, magnitude wrapped to 0
//                busy      - arbiter not idle
//  Modports    : slave  - arbiter side
//                master - requester / consumer side
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface magnitude_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*17-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           out_mag;
  logic [ID_W-1:0]       out_id;
  logic                  out_ovf;
  logic                  busy;

  modport slave (
    input  req, req_data, out_ready,
    output ack, out_valid, out_mag, out_id, out_ovf, busy
  );

  modport master (
    output req, req_data, out_ready,
    input  ack, out_valid, out_mag, out_id, out_ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/magnitude_arbiter.sv
// ============================================================================
//  Module      : magnitude_arbiter
//  Description : Round-robin scheduler sharing one 17-bit two's-complement to
//                16-bit magnitude datapath among NUM_REQ requesters. Grants one
//                requester at a time, latches its sample, computes the
//                magnitude in a registered stage and presents it on a
//                valid/ready port tagged with the requester index.
//  Parameters  : NUM_REQ - number of requesters (2..8)
//                ID_W    - requester index width, clog2(NUM_REQ); must match
//                          the parameters of the connected interface instance
//  Ports       : clk   - system clock, rising edge
//                n_rst - synchronous active-low reset
//                bus   - magnitude_arbiter_if.slave (req/ack, result port)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module magnitude_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  wire logic             clk,
  input  wire logic             n_rst,
  magnitude_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  localparam logic [16:0] C_MOST_NEG = 17'h10000;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [16:0]         r_sample;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_out_valid;
  logic [15:0]         r_out_mag;
  logic [ID_W-1:0]     r_out_id;
  logic                r_out_ovf;

  logic                w_found;
  logic [ID_W-1:0]     w_sel;
  logic [ID_W-1:0]     w_cand;
  logic [15:0]         w_mag;
  logic                w_ovf;

  // Modulo-NUM_REQ increment; NUM_REQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) begin
      return '0;
    end else begin
      return v + 1'b1;
    end
  endfunction

  // Round-robin search starting at r_ptr: first active request wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  // Only the low 16 bits of the negation are kept, so -65536 wraps to 0 and
  // is flagged separately.
  always_comb begin
    w_mag = r_sample[15:0];
    if (r_sample[16]) begin
      w_mag = ~r_sample[15:0] + 16'd1;
    end
    w_ovf = (r_sample == C_MOST_NEG);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_sample    <= '0;
      r_ack       <= '0;
      r_out_valid <= 1'b0;
      r_out_mag   <= '0;
      r_out_id    <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sample       <= bus.req_data[int'(w_sel)*17 +: 17];
            r_grant        <= w_sel;
            r_ack[w_sel]   <= 1'b1;
            r_ptr          <= wrap_inc(w_sel);
            r_state        <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_out_mag   <= w_mag;
          r_out_id    <= r_grant;
          r_out_ovf   <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          // Result fields keep their last value after the handshake.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.out_valid = r_out_valid;
  assign bus.out_mag   = r_out_mag;
  assign bus.out_id    = r_out_id;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_magnitude_arbiter.sv
// ============================================================================
//  Module      : tb_magnitude_arbiter
//  Description : Directed scoreboard bench for magnitude_arbiter. Stimulus
//                pushes expected results into a queue; a monitor pops and
//                compares on every out_valid/out_ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_magnitude_arbiter;

  typedef struct packed {
    logic [15:0] mag;
    logic [1:0]  id;
    logic        ovf;
  } exp_t;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  exp_t q[$];

  magnitude_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  magnitude_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [15:0] m, input logic [1:0] id, input logic ovf);
    exp_t e;
    e.mag = m;
    e.id  = id;
    e.ovf = ovf;
    return e;
  endfunction

  // One isolated request through the full IDLE->COMPUTE->HOLD->IDLE loop,
  // out_ready assumed high. Entered and left with the DUT idle.
  task automatic single(input int idx, input logic [16:0] data,
                        input logic [15:0] emag, input logic eovf);
    bus.req_data[17*idx +: 17] = data;
    bus.req = 4'b0001 << idx;
    q.push_back(mk(emag, 2'(idx), eovf));
    tick();
    chk("single_ack", 32'(bus.ack), 32'(4'b0001 << idx));
    bus.req = 4'b0000;
    tick();
    chk("single_valid_lat2", 32'(bus.out_valid), 32'd1);
    chk("single_ack_pulse", 32'(bus.ack), 32'd0);
    tick();
    chk("single_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  // Scoreboard monitor: handshake is sampled mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got mag=%0h id=%0d expected none at %0t",
                   bus.out_mag, bus.out_id, $time);
        end else begin
          e = q.pop_front();
          chk("mon_mag", 32'(bus.out_mag), 32'(e.mag));
          chk("mon_id",  32'(bus.out_id),  32'(e.id));
          chk("mon_ovf", 32'(bus.out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    n_rst         = 1'b0;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    bus.req_data  = '0;
    bus.req_data[0*17 +: 17] = 17'h00010;
    bus.req_data[1*17 +: 17] = 17'h1FFF0;
    bus.req_data[2*17 +: 17] = 17'h00200;
    bus.req_data[3*17 +: 17] = 17'h00300;

    // Reset with all requests active
    repeat (3) tick();
    chk("rst_ack",   32'(bus.ack),       32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mag",   32'(bus.out_mag),   32'd0);
    chk("rst_id",    32'(bus.out_id),    32'd0);
    chk("rst_ovf",   32'(bus.out_ovf),   32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);

    q.push_back(mk(16'h0010, 2'd0, 1'b0));
    n_rst = 1'b1;
    tick();
    chk("post_rst_ack", 32'(bus.ack),  32'b0001);
    chk("post_rst_busy", 32'(bus.busy), 32'd1);
    bus.req = 4'b0000;
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("post_rst_drop", 32'(bus.out_valid), 32'd0);
    chk("post_rst_idle", 32'(bus.busy),      32'd0);

    // Single positive request, then signed edge values via requester 1
    single(2, 17'h00123, 16'h0123, 1'b0);
    single(1, 17'h1FFFF, 16'h0001, 1'b0);
    single(1, 17'h18000, 16'h8000, 1'b0);
    single(1, 17'h10000, 16'h0000, 1'b1);
    single(1, 17'h0FFFF, 16'hFFFF, 1'b0);
    // Requester 3 leaves ptr at 0 for the fairness sweep
    single(3, 17'h1FF00, 16'h0100, 1'b0);

    // Fairness: all requests held, one grant every 3 cycles
    bus.req_data[0*17 +: 17] = 17'h00005;
    bus.req_data[1*17 +: 17] = 17'h1FFF9;
    bus.req_data[2*17 +: 17] = 17'h00042;
    bus.req_data[3*17 +: 17] = 17'h1C000;
    for (int g = 0; g < 8; g++) begin
      case (g % 4)
        0: q.push_back(mk(16'h0005, 2'd0, 1'b0));
        1: q.push_back(mk(16'h0007, 2'd1, 1'b0));
        2: q.push_back(mk(16'h0042, 2'd2, 1'b0));
        default: q.push_back(mk(16'h4000, 2'd3, 1'b0));
      endcase
    end
    bus.req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      tick();
      chk("rr_ack", 32'(bus.ack), 32'(4'b0001 << (g % 4)));
      if (g == 7) bus.req = 4'b0000;
      tick();
      chk("rr_valid", 32'(bus.out_valid), 32'd1);
      chk("rr_ack_gap", 32'(bus.ack), 32'd0);
      tick();
      chk("rr_drop", 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: 10-cycle stall with another request pending
    bus.out_ready = 1'b0;
    bus.req_data[0*17 +: 17] = 17'h0ABCD;
    bus.req_data[2*17 +: 17] = 17'h00777;
    q.push_back(mk(16'hABCD, 2'd0, 1'b0));
    q.push_back(mk(16'h0777, 2'd2, 1'b0));
    bus.req = 4'b0001;
    tick();
    chk("bp_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0100;
    tick();
    chk("bp_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_mag",   32'(bus.out_mag),   32'hABCD);
      chk("bp_hold_id",    32'(bus.out_id),    32'd0);
      chk("bp_no_ack",     32'(bus.ack),       32'd0);
      chk("bp_busy",       32'(bus.busy),      32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_release_noack", 32'(bus.ack), 32'd0);
    tick();
    chk("bp_next_ack", 32'(bus.ack), 32'b0100);
    bus.req = 4'b0000;
    tick();
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // Reset mid-operation: result in HOLD is discarded, ptr back to 0
    bus.out_ready = 1'b0;
    bus.req_data[1*17 +: 17] = 17'h00055;
    bus.req = 4'b0010;
    tick();
    chk("mid_ack", 32'(bus.ack), 32'b0010);
    bus.req = 4'b0000;
    tick();
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    tick();
    n_rst = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),      32'd0);
    chk("mid_rst_ack",   32'(bus.ack),       32'd0);
    bus.out_ready = 1'b1;
    bus.req_data[0*17 +: 17] = 17'h00099;
    q.push_back(mk(16'h0099, 2'd0, 1'b0));
    n_rst   = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk("mid_ptr0_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    tick();
    chk("mid_post_valid", 32'(bus.out_valid), 32'd1);
    repeat (3) tick();

    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
